// File: rtl/reg_field_master.sv
// Single-outstanding bus initiator for the BD_CONTROL/BD_DATA register field.
// Commands arrive over valid/ready; responses carry read data and an error flag.
module reg_field_master #(
  parameter int         BASE_ADDR     = 48,
  parameter int         NUM_REGS      = 3,
  parameter logic [7:0] IDLE_ADDR     = 8'd0,
  parameter bit         VERIFY_WRITES = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  input  logic [7:0] bus_rdata,
  input  logic [7:0] bus_addr_echo,
  output logic [7:0] err_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       verify_q, verify_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic       bus_we_q, bus_we_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] err_count_q, err_count_d;
  logic       cmd_ready_q, cmd_ready_d;

  logic in_range;
  logic read_err;

  assign in_range = (int'(cmd_addr) >= BASE_ADDR) && (int'(cmd_addr) < BASE_ADDR + NUM_REGS);
  assign read_err = (bus_addr_echo != addr_q) || (verify_q && (bus_rdata != wdata_q));

  always_comb begin
    state_d     = state_q;
    verify_d    = verify_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          verify_d = 1'b0;
          if (!in_range) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 8'h00;
            rsp_err_d   = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else if (cmd_write) begin
            state_d     = S_WRITE;
            bus_addr_d  = cmd_addr;
            bus_wdata_d = cmd_wdata;
            bus_we_d    = 1'b1;
          end else begin
            state_d    = S_READ;
            bus_addr_d = cmd_addr;
          end
        end
      end
      S_WRITE: begin
        // With verify the address stays on the bus so the next cycle reads it back.
        if (VERIFY_WRITES) begin
          state_d  = S_READ;
          verify_d = 1'b1;
        end else begin
          state_d     = S_RESP;
          bus_addr_d  = IDLE_ADDR;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b0;
        end
      end
      S_READ: begin
        state_d     = S_RESP;
        bus_addr_d  = IDLE_ADDR;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus_rdata;
        rsp_err_d   = read_err;
        if (read_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
      default: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      verify_q    <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      bus_addr_q  <= IDLE_ADDR;
      bus_wdata_q <= 8'h00;
      bus_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'h00;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      verify_q    <= verify_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_reg_field_master.sv
// Directed bench for reg_field_master: a plain instance and a write-verify instance,
// each attached to a falling-edge register-field model.
module tb_reg_field_master;

  logic       clk;
  logic       rst_n;
  logic       cmdValid, vCmdValid;
  logic       cmdWrite;
  logic [7:0] cmdAddr, cmdWdata;
  logic       rspReady;

  logic       cmdReady, rspValid, rspErr, busWe;
  logic [7:0] rspRdata, busAddr, busWdata, errCount;
  logic [7:0] fRdata, fEcho;

  logic       vCmdReady, vRspValid, vRspErr, vBusWe;
  logic [7:0] vRspRdata, vBusAddr, vBusWdata, vErrCount;
  logic [7:0] vRdata, vEcho;

  logic [7:0] mem  [4];
  logic [7:0] vMem [4];

  int vectors;
  int miscompares;
  int weCount;
  logic [7:0] weAddr, weData;

  reg_field_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_write(cmdWrite),
    .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr),
    .bus_addr(busAddr), .bus_wdata(busWdata), .bus_we(busWe),
    .bus_rdata(fRdata), .bus_addr_echo(fEcho), .err_count(errCount)
  );

  reg_field_master #(.VERIFY_WRITES(1'b1)) dutVerify (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(vCmdValid), .cmd_ready(vCmdReady), .cmd_write(cmdWrite),
    .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata),
    .rsp_valid(vRspValid), .rsp_ready(rspReady), .rsp_rdata(vRspRdata), .rsp_err(vRspErr),
    .bus_addr(vBusAddr), .bus_wdata(vBusWdata), .bus_we(vBusWe),
    .bus_rdata(vRdata), .bus_addr_echo(vEcho), .err_count(vErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i]  = 8'h00;
      vMem[i] = 8'h00;
    end
    weCount = 0;
  end

  // Field model: registered read data and address echo, writes on the falling edge.
  always @(negedge clk) begin
    fEcho  <= busAddr;
    fRdata <= (busAddr >= 8'd48 && busAddr <= 8'd50) ? mem[busAddr[1:0]] : 8'h00;
    if (busWe && busAddr >= 8'd48 && busAddr <= 8'd50) mem[busAddr[1:0]] <= busWdata;
    if (busWe) begin
      weCount = weCount + 1;
      weAddr  = busAddr;
      weData  = busWdata;
    end
  end

  // The verify instance's field corrupts bit 0 of anything stored at address 50.
  always @(negedge clk) begin
    vEcho  <= vBusAddr;
    vRdata <= (vBusAddr >= 8'd48 && vBusAddr <= 8'd50) ? vMem[vBusAddr[1:0]] : 8'h00;
    if (vBusWe && vBusAddr >= 8'd48 && vBusAddr <= 8'd50)
      vMem[vBusAddr[1:0]] <= (vBusAddr == 8'd50) ? (vBusWdata ^ 8'h01) : vBusWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called #1 after an edge with the target idle; returns once rsp_valid is seen or the budget runs out.
  task automatic applyStimulus(input bit sel, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                               output logic [7:0] rdata, output logic err, output int lat);
    cmdWrite = wr;
    cmdAddr  = addr;
    cmdWdata = wdata;
    if (sel) vCmdValid = 1'b1;
    else     cmdValid  = 1'b1;
    @(posedge clk); #1;
    cmdValid  = 1'b0;
    vCmdValid = 1'b0;
    lat = 1;
    while (!(sel ? vRspValid : rspValid) && lat < 8) begin
      @(posedge clk); #1;
      lat = lat + 1;
    end
    rdata = sel ? vRspRdata : rspRdata;
    err   = sel ? vRspErr : rspErr;
  endtask

  task automatic completeResp();
    @(posedge clk); #1;
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;
  int         weBefore;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    cmdValid  = 1'b0;
    vCmdValid = 1'b0;
    cmdWrite  = 1'b0;
    cmdAddr   = 8'h00;
    cmdWdata  = 8'h00;
    rspReady  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmdReady, 1);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_bus_we", busWe, 0);
    checkOutput("rst_bus_addr", busAddr, 8'h00);
    checkOutput("rst_bus_wdata", busWdata, 8'h00);
    checkOutput("rst_rsp_rdata", rspRdata, 8'h00);
    checkOutput("rst_rsp_err", rspErr, 0);
    checkOutput("rst_err_count", errCount, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 0, 8'd48, 8'h00, rd, er, lat);
    checkOutput("rd48_lat", lat, 2);
    checkOutput("rd48_data", rd, 8'h00);
    checkOutput("rd48_err", er, 0);
    completeResp();

    weBefore = weCount;
    applyStimulus(0, 1, 8'd49, 8'hA5, rd, er, lat);
    checkOutput("wr49_lat", lat, 2);
    checkOutput("wr49_err", er, 0);
    checkOutput("wr49_rdata", rd, 8'h00);
    checkOutput("wr49_we_cycles", weCount - weBefore, 1);
    checkOutput("wr49_bus_addr", weAddr, 8'd49);
    checkOutput("wr49_bus_data", weData, 8'hA5);
    checkOutput("wr49_field", mem[1], 8'hA5);
    completeResp();

    applyStimulus(0, 0, 8'd49, 8'h00, rd, er, lat);
    checkOutput("rd49_lat", lat, 2);
    checkOutput("rd49_data", rd, 8'hA5);
    checkOutput("rd49_err", er, 0);
    completeResp();

    applyStimulus(0, 1, 8'd50, 8'h5A, rd, er, lat);
    completeResp();
    applyStimulus(0, 0, 8'd50, 8'h00, rd, er, lat);
    checkOutput("rd50_data", rd, 8'h5A);
    checkOutput("rd50_err", er, 0);
    completeResp();

    weBefore = weCount;
    applyStimulus(0, 0, 8'd51, 8'h00, rd, er, lat);
    checkOutput("oor51_lat", lat, 1);
    checkOutput("oor51_err", er, 1);
    checkOutput("oor51_rdata", rd, 8'h00);
    checkOutput("oor51_bus_addr", busAddr, 8'h00);
    checkOutput("oor51_err_count", errCount, 1);
    completeResp();
    checkOutput("oor51_no_we", weCount - weBefore, 0);

    applyStimulus(0, 1, 8'd47, 8'h99, rd, er, lat);
    checkOutput("oor47_err", er, 1);
    checkOutput("oor47_err_count", errCount, 2);
    completeResp();

    // Hold the response while a competing write command waits at the input.
    rspReady = 1'b0;
    applyStimulus(0, 0, 8'd48, 8'h00, rd, er, lat);
    checkOutput("hold_lat", lat, 2);
    cmdWrite = 1'b1;
    cmdAddr  = 8'd48;
    cmdWdata = 8'h77;
    cmdValid = 1'b1;
    weBefore = weCount;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", rspValid, 1);
      checkOutput("hold_rdata", rspRdata, 8'h00);
      checkOutput("hold_err", rspErr, 0);
      checkOutput("hold_cmd_ready", cmdReady, 0);
      checkOutput("hold_bus_addr", busAddr, 8'h00);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_valid", rspValid, 0);
    checkOutput("release_cmd_ready", cmdReady, 1);
    checkOutput("hold_no_we", weCount - weBefore, 0);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    checkOutput("next_accept_we", busWe, 1);
    checkOutput("next_accept_addr", busAddr, 8'd48);
    checkOutput("next_accept_ready", cmdReady, 0);
    @(posedge clk); #1;
    checkOutput("next_rsp_valid", rspValid, 1);
    checkOutput("next_rsp_err", rspErr, 0);
    completeResp();
    applyStimulus(0, 0, 8'd48, 8'h00, rd, er, lat);
    checkOutput("rd48_after_hold", rd, 8'h77);
    completeResp();

    // Reset in the middle of a write must drop the strobe and any response.
    cmdWrite = 1'b1;
    cmdAddr  = 8'd50;
    cmdWdata = 8'h11;
    cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    checkOutput("midwr_we_up", busWe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midwr_we_drop", busWe, 0);
    checkOutput("midwr_rsp_valid", rspValid, 0);
    checkOutput("midwr_err_count", errCount, 0);
    checkOutput("midwr_bus_addr", busAddr, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midwr_no_rsp", rspValid, 0);
    checkOutput("midwr_field", mem[2], 8'h5A);
    checkOutput("midwr_ready", cmdReady, 1);

    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, 8'd0, 8'h00, rd, er, lat);
      completeResp();
      if (i == 253) checkOutput("errcnt_254", errCount, 254);
      if (i == 254) checkOutput("errcnt_255", errCount, 255);
    end
    checkOutput("errcnt_sat", errCount, 255);

    applyStimulus(1, 1, 8'd50, 8'h3C, rd, er, lat);
    checkOutput("vwr50_lat", lat, 3);
    checkOutput("vwr50_err", er, 1);
    checkOutput("vwr50_rdata", rd, 8'h3D);
    checkOutput("vwr50_err_count", vErrCount, 1);
    completeResp();
    applyStimulus(1, 1, 8'd49, 8'h42, rd, er, lat);
    checkOutput("vwr49_lat", lat, 3);
    checkOutput("vwr49_err", er, 0);
    checkOutput("vwr49_rdata", rd, 8'h42);
    checkOutput("vwr49_err_count", vErrCount, 1);
    completeResp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
